// File: rtl/spi_ram_pkg.sv
// Shared command encoding and field positions for the SPI RAM stage.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic {
        PTR_IDLE  = 1'b0,
        PTR_ARMED = 1'b1
    } ptr_state_t;

    localparam int CMD_MSB   = 9;
    localparam int CMD_LSB   = 8;
    localparam int PAYLOAD_W = 8;

endpackage

// File: rtl/spi_ram_ptr.sv
// Address pointer for one direction: address register, armed flag,
// range check against the memory depth and optional post-access increment.
module spi_ram_ptr
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 adv,
    input  logic [ADDR_SIZE-1:0] payload,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 ok,
    output logic                 range_err
);

    localparam logic [ADDR_SIZE:0]   DEPTH_V   = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = ADDR_SIZE'(1);

    ptr_state_t             state_r;
    ptr_state_t             state_nxt_s;
    logic [ADDR_SIZE-1:0]   addr_r;
    logic [ADDR_SIZE-1:0]   addr_nxt_s;
    logic                   legal_s;

    assign legal_s = ({1'b0, payload} < DEPTH_V);
    assign addr    = addr_r;
    assign ok      = (state_r == PTR_ARMED);

    // State and address registers; reset disarms and zeroes the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= PTR_IDLE;
            addr_r  <= {ADDR_SIZE{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
        end
    end

    // Next state, next address and range error; once armed only reset disarms.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        range_err   = 1'b0;
        case (state_r)
            PTR_IDLE: begin
                if (load && legal_s) begin
                    state_nxt_s = PTR_ARMED;
                end else begin
                    state_nxt_s = PTR_IDLE;
                end
            end
            PTR_ARMED: state_nxt_s = PTR_ARMED;
            default:   state_nxt_s = PTR_IDLE;
        endcase
        if (load) begin
            if (legal_s) begin
                addr_nxt_s = payload;
            end else begin
                range_err = 1'b1;
            end
        end else if (adv && (AUTO_INC != 0)) begin
            if (addr_r == LAST_ADDR) begin
                addr_nxt_s = {ADDR_SIZE{1'b0}};
            end else begin
                addr_nxt_s = addr_r + ONE_ADDR;
            end
        end else begin
            addr_nxt_s = addr_r;
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Single-port RAM behind the SPI slave: decodes 10-bit command words,
// keeps independent write/read pointers and returns read data to the slave.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [7:0]             mem_r [MEM_DEPTH];
    cmd_t                   cmd_s;
    logic [PAYLOAD_W-1:0]   payload_s;
    logic                   wr_load_s, wr_adv_s, rd_load_s, rd_adv_s;
    logic                   unarmed_err_s, err_nxt_s;
    logic [ADDR_SIZE-1:0]   wr_addr_s, rd_addr_s;
    logic                   wr_ok_s, rd_ok_s;
    logic                   wr_range_err_s, rd_range_err_s;
    logic [7:0]             tx_data_r;
    logic                   tx_valid_r, cmd_err_r;

    assign cmd_s     = cmd_t'(rx_data[CMD_MSB:CMD_LSB]);
    assign payload_s = rx_data[PAYLOAD_W-1:0];
    assign err_nxt_s = unarmed_err_s | wr_range_err_s | rd_range_err_s;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign cmd_err   = cmd_err_r;

    // Command decode: address loads, armed data accesses, unarmed rejections.
    always_comb begin
        wr_load_s     = 1'b0;
        wr_adv_s      = 1'b0;
        rd_load_s     = 1'b0;
        rd_adv_s      = 1'b0;
        unarmed_err_s = 1'b0;
        if (rx_valid) begin
            case (cmd_s)
                WR_ADDR: wr_load_s = 1'b1;
                WR_DATA: begin
                    if (wr_ok_s) wr_adv_s      = 1'b1;
                    else         unarmed_err_s = 1'b1;
                end
                RD_ADDR: rd_load_s = 1'b1;
                RD_DATA: begin
                    if (rd_ok_s) rd_adv_s      = 1'b1;
                    else         unarmed_err_s = 1'b1;
                end
                default: unarmed_err_s = 1'b0;
            endcase
        end else begin
            unarmed_err_s = 1'b0;
        end
    end

    spi_ram_ptr #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE), .AUTO_INC(AUTO_INC)) u_wr_ptr (
        .clk(clk), .rst(rst), .load(wr_load_s), .adv(wr_adv_s), .payload(payload_s),
        .addr(wr_addr_s), .ok(wr_ok_s), .range_err(wr_range_err_s)
    );

    spi_ram_ptr #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE), .AUTO_INC(AUTO_INC)) u_rd_ptr (
        .clk(clk), .rst(rst), .load(rd_load_s), .adv(rd_adv_s), .payload(payload_s),
        .addr(rd_addr_s), .ok(rd_ok_s), .range_err(rd_range_err_s)
    );

    // Memory write; contents survive reset but no write happens while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_adv_s) begin
            mem_r[wr_addr_s[MEM_AW-1:0]] <= payload_s;
        end
    end

    // Registered responses: single-cycle pulses, tx_data held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            cmd_err_r  <= 1'b0;
        end else begin
            tx_valid_r <= rd_adv_s;
            cmd_err_r  <= err_nxt_s;
            if (rd_adv_s) begin
                tx_data_r <= mem_r[rd_addr_s[MEM_AW-1:0]];
            end
        end
    end

endmodule
